// File: rtl/alu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module : alu_rr_scheduler
// Brief  : Round-robin sharing of one external combinational ALU between two
//          valid/ready requesters, with registered operands and response.
// Rev    : 1.0  initial release
// ============================================================================
module alu_rr_scheduler #(
  parameter int WIDTH = 4,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic [OPW-1:0]   req0_op_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  input  logic [OPW-1:0]   req1_op_i,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  output logic [OPW-1:0]   alu_opcode_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_err_o,
  output logic             busy_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q,      state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q,         id_d;
  logic [WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WIDTH-1:0] alu_b_q,      alu_b_d;
  logic [OPW-1:0]   alu_op_q,     alu_op_d;
  logic             rsp_valid_q,  rsp_valid_d;
  logic             rsp_id_q,     rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_err_q,    rsp_err_d;

  logic w_idle;
  logic w_any;
  logic w_pick1;

  always_comb begin
    w_idle  = (state_q == ST_IDLE);
    w_any   = req0_valid_i | req1_valid_i;
    // On a tie the requester that was not served last wins.
    w_pick1 = (req0_valid_i && req1_valid_i) ? ~last_grant_q : req1_valid_i;
  end

  assign req0_ready_o = w_idle & w_any & ~w_pick1;
  assign req1_ready_o = w_idle & w_any &  w_pick1;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (w_any) begin
          state_d      = ST_EXEC;
          id_d         = w_pick1;
          last_grant_d = w_pick1;
          alu_a_d      = w_pick1 ? req1_a_i  : req0_a_i;
          alu_b_d      = w_pick1 ? req1_b_i  : req0_b_i;
          alu_op_d     = w_pick1 ? req1_op_i : req0_op_i;
        end
      end
      ST_EXEC: begin
        state_d      = ST_RESP;
        rsp_valid_d  = 1'b1;
        rsp_id_d     = id_q;
        // The top opcode bit marks an unsupported op: report it, zero the data.
        rsp_err_d    = alu_op_q[OPW-1];
        rsp_result_d = alu_op_q[OPW-1] ? '0 : alu_result_i;
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a_o      = alu_a_q;
  assign alu_b_o      = alu_b_q;
  assign alu_opcode_o = alu_op_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule
`default_nettype wire
